// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared sizes and scan state encoding for the register bank
package cpu_pkg;

  localparam int WIDTH = 4;
  localparam int NREG  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - one-shot sequencer stepping the read select through all registers
module scan_ctrl
  import cpu_pkg::*;
#(
  parameter int SEL_W_P = SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_start,
  output logic               scan_busy,
  output logic               scan_valid,
  output logic               scan_done,
  output logic [SEL_W_P-1:0] scan_sel
);

  scan_state_e        state_q, state_d;
  logic [SEL_W_P-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        // Leave on the last register so the counter never wraps into a second pass.
        if (&cnt_q) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + SEL_W_P'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign scan_busy  = (state_q == SCAN) || (state_q == DONE);
  assign scan_valid = (state_q == SCAN);
  assign scan_done  = (state_q == DONE);
  assign scan_sel   = cnt_q;

endmodule

// File: rtl/reg_bank_8x4.sv
// rtl/reg_bank_8x4.sv - eight 4-bit registers feeding the read mux, with select and scan
module reg_bank_8x4
  import cpu_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int NREG_P  = NREG,
  parameter int SEL_W_P = SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [SEL_W_P-1:0] wr_addr,
  input  logic [WIDTH_P-1:0] wr_data,
  input  logic               clr,
  input  logic [SEL_W_P-1:0] sel_in,
  input  logic               scan_start,
  output logic               scan_busy,
  output logic               scan_valid,
  output logic               scan_done,
  output logic [SEL_W_P-1:0] sel_out,
  output logic [WIDTH_P-1:0] q0,
  output logic [WIDTH_P-1:0] q1,
  output logic [WIDTH_P-1:0] q2,
  output logic [WIDTH_P-1:0] q3,
  output logic [WIDTH_P-1:0] q4,
  output logic [WIDTH_P-1:0] q5,
  output logic [WIDTH_P-1:0] q6,
  output logic [WIDTH_P-1:0] q7
);

  logic [WIDTH_P-1:0] regs_q [NREG_P];
  logic [WIDTH_P-1:0] regs_d [NREG_P];
  logic [SEL_W_P-1:0] scan_sel;

  // Clear wins over a same-cycle write; the scan never gates either.
  always_comb begin
    for (int i = 0; i < NREG_P; i++) regs_d[i] = regs_q[i];
    if (clr) begin
      for (int i = 0; i < NREG_P; i++) regs_d[i] = '0;
    end else if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG_P; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG_P; i++) regs_q[i] <= regs_d[i];
    end
  end

  scan_ctrl #(.SEL_W_P(SEL_W_P)) u_scan_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_valid (scan_valid),
    .scan_done  (scan_done),
    .scan_sel   (scan_sel)
  );

  assign sel_out = scan_valid ? scan_sel : sel_in;

  assign q0 = regs_q[0];
  assign q1 = regs_q[1];
  assign q2 = regs_q[2];
  assign q3 = regs_q[3];
  assign q4 = regs_q[4];
  assign q5 = regs_q[5];
  assign q6 = regs_q[6];
  assign q7 = regs_q[7];

endmodule

// File: tb/tb_reg_bank_8x4.sv
// tb/tb_reg_bank_8x4.sv - randomized and directed self-checking bench for reg_bank_8x4
module tb_reg_bank_8x4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       clr;
  logic [2:0] sel_in;
  logic       scan_start;
  logic       scan_busy, scan_valid, scan_done;
  logic [2:0] sel_out;
  logic [3:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [3:0] q_obs [8];

  int checks = 0;
  int errors = 0;

  // Reference: register contents plus cycles elapsed since an accepted scan_start (0 = idle).
  logic [3:0] m_regs [8];
  int         m_t;

  always #5 clk = ~clk;

  reg_bank_8x4 dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .sel_in(sel_in), .scan_start(scan_start), .scan_busy(scan_busy),
    .scan_valid(scan_valid), .scan_done(scan_done), .sel_out(sel_out),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7)
  );

  assign q_obs[0] = q0;
  assign q_obs[1] = q1;
  assign q_obs[2] = q2;
  assign q_obs[3] = q3;
  assign q_obs[4] = q4;
  assign q_obs[5] = q5;
  assign q_obs[6] = q6;
  assign q_obs[7] = q7;

  function automatic logic m_busy();  return m_t >= 1;              endfunction
  function automatic logic m_valid(); return m_t >= 1 && m_t <= 8;  endfunction
  function automatic logic m_done();  return m_t == 9;              endfunction
  function automatic logic [2:0] m_sel();
    return m_valid() ? 3'(m_t - 1) : sel_in;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 4'h0;
    m_t = 0;
  endtask

  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'h0; clr = 1'b0; scan_start = 1'b0;
  endtask

  // Advance one clock edge, update the reference from the inputs seen at that edge, settle.
  task automatic tick();
    @(posedge clk);
    if (clr) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 4'h0;
    end else if (wr_en) begin
      m_regs[wr_addr] = wr_data;
    end
    if (m_t == 0) begin
      if (scan_start) m_t = 1;
    end else if (m_t == 9) begin
      m_t = 0;
    end else begin
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0; sel_in = 3'd5;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q_obs[i] !== 4'h0) begin
        errors++; $display("FAIL reset_q%0d: got %0h expected 0", i, q_obs[i]);
      end
    end
    checks++;
    if ({scan_busy, scan_valid, scan_done} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {scan_busy, scan_valid, scan_done});
    end
    checks++;
    if (sel_out !== 3'd5) begin
      errors++; $display("FAIL reset_sel: got %0d expected 5", sel_out);
    end
    sel_in = 3'd2; #1;
    checks++;
    if (sel_out !== 3'd2) begin
      errors++; $display("FAIL idle_passthru: got %0d expected 2", sel_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_all();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
      tick();
      checks++;
      if (q_obs[i] !== 4'(i + 1)) begin
        errors++; $display("FAIL write_q%0d: got %0h expected %0h", i, q_obs[i], i + 1);
      end
    end
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q_obs[i] !== 4'(i + 1)) begin
        errors++; $display("FAIL write_hold_q%0d: got %0h expected %0h", i, q_obs[i], i + 1);
      end
    end
  endtask

  task automatic test_clear_vs_write();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA; clr = 1'b1;
    tick();
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q_obs[i] !== 4'h0) begin
        errors++; $display("FAIL clr_beats_wr_q%0d: got %0h expected 0", i, q_obs[i]);
      end
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
      tick();
    end
    drive_idle();
  endtask

  task automatic test_full_scan();
    preload();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel_in = 3'($urandom_range(0, 7)); #1;
      checks++;
      if ({scan_busy, scan_valid, scan_done} !== 3'b110) begin
        errors++; $display("FAIL scan_flags_%0d: got %b expected 110", i, {scan_busy, scan_valid, scan_done});
      end
      checks++;
      if (sel_out !== 3'(i) || q_obs[sel_out] !== 4'(i + 1)) begin
        errors++; $display("FAIL scan_sel_%0d: got sel %0d data %0h expected sel %0d data %0h", i, sel_out, q_obs[sel_out], i, i + 1);
      end
      scan_start = (i == 3 || i == 7);
      tick();
      scan_start = 1'b0;
    end
    sel_in = 3'd6; #1;
    checks++;
    if ({scan_busy, scan_valid, scan_done} !== 3'b101 || sel_out !== 3'd6) begin
      errors++; $display("FAIL scan_done: got flags %b sel %0d expected 101 sel 6", {scan_busy, scan_valid, scan_done}, sel_out);
    end
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    checks++;
    if ({scan_busy, scan_valid, scan_done} !== 3'b000) begin
      errors++; $display("FAIL scan_end: got %b expected 000", {scan_busy, scan_valid, scan_done});
    end
    tick();
    checks++;
    if (scan_busy !== 1'b0) begin
      errors++; $display("FAIL scan_no_requeue: got busy %b expected 0", scan_busy);
    end
  endtask

  task automatic test_write_during_scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        checks++;
        if (sel_out !== 3'd5 || q5 !== 4'hF) begin
          errors++; $display("FAIL wr_during_scan: got sel %0d q5 %0h expected sel 5 q5 f", sel_out, q5);
        end
      end
      wr_en = (i == 4); wr_addr = 3'd5; wr_data = 4'hF;
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_scan();
    preload();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (sel_out !== 3'd3) begin
      errors++; $display("FAIL mid_scan_pos: got %0d expected 3", sel_out);
    end
    rst_n = 1'b0; sel_in = 3'd1; #1;
    model_reset();
    checks++;
    if ({scan_busy, scan_valid, scan_done} !== 3'b000 || sel_out !== 3'd1) begin
      errors++; $display("FAIL mid_scan_abort: got flags %b sel %0d expected 000 sel 1", {scan_busy, scan_valid, scan_done}, sel_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q_obs[i] !== 4'h0) begin
        errors++; $display("FAIL mid_scan_q%0d: got %0h expected 0", i, q_obs[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (scan_done !== 1'b0 || scan_busy !== 1'b0) begin
        errors++; $display("FAIL post_abort_%0d: got busy %b done %b expected 0 0", i, scan_busy, scan_done);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = 3'($urandom_range(0, 7));
      wr_data    = 4'($urandom_range(0, 15));
      clr        = ($urandom_range(0, 19) == 0);
      scan_start = ($urandom_range(0, 5) == 0);
      sel_in     = 3'($urandom_range(0, 7));
      tick();
      sel_in = 3'($urandom_range(0, 7)); #1;
      checks++;
      if ({scan_busy, scan_valid, scan_done} !== {m_busy(), m_valid(), m_done()}) begin
        errors++; $display("FAIL rand_flags_%0d: got %b expected %b", n, {scan_busy, scan_valid, scan_done}, {m_busy(), m_valid(), m_done()});
      end
      checks++;
      if (sel_out !== m_sel()) begin
        errors++; $display("FAIL rand_sel_%0d: got %0d expected %0d", n, sel_out, m_sel());
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_obs[i] !== m_regs[i]) begin
          errors++; $display("FAIL rand_q%0d_%0d: got %0h expected %0h", i, n, q_obs[i], m_regs[i]);
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_write_all();
    test_clear_vs_write();
    test_full_scan();
    test_write_during_scan();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
